// File: rtl/stream_pkg.sv
// Shared identifiers and types for the two-input stream merge.
package stream_pkg;

  localparam logic ID_S0 = 1'b0;
  localparam logic ID_S1 = 1'b1;

  // Bit N is the request/grant of input N.
  typedef logic [1:0] req_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter with an optional packet lock.
module rr_arb2
  import stream_pkg::*;
(
  input  req_t req_i,
  input  logic ptr_i,
  input  logic lock_i,
  input  logic lock_id_i,
  output req_t gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (lock_i) begin
      gnt_o[lock_id_i] = req_i[lock_id_i];
    end else begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        // Contention: favour the input that was not served last.
        2'b11:   gnt_o = (ptr_i == ID_S0) ? 2'b10 : 2'b01;
        default: gnt_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/stream_rr_merge.sv
// Two-input round-robin stream merge with a forward-registered output stage.
// Define STREAM_RR_MERGE_LAST_LOCK_EN to hold the grant for a whole packet (until last).
module stream_rr_merge
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WD = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_WD-1:0] s0_data,
  input  logic               s0_last,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic [DATA_WD-1:0] s1_data,
  input  logic               s1_last,
  input  logic               s1_valid,
  output logic               s1_ready,
  output logic [DATA_WD-1:0] m_data,
  output logic               m_last,
  output logic               m_id,
  output logic               m_valid,
  input  logic               m_ready
);

  logic [DATA_WD-1:0] m_data_q, m_data_d;
  logic               m_last_q, m_last_d;
  logic               m_id_q, m_id_d;
  logic               m_valid_q, m_valid_d;
  logic               rr_ptr_q, rr_ptr_d;

  logic               lock;
  logic               lock_id;
  logic               load;
  logic               fire;
  logic               gid;
  logic [DATA_WD-1:0] sel_data;
  logic               sel_last;
  req_t               req;
  req_t               gnt;

  // Only path from m_ready to the input readies.
  assign load = !m_valid_q || m_ready;
  assign req  = {s1_valid, s0_valid};

  rr_arb2 u_arb (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .lock_i    (lock),
    .lock_id_i (lock_id),
    .gnt_o     (gnt)
  );

  assign s0_ready = load && gnt[0];
  assign s1_ready = load && gnt[1];
  assign fire     = load && (gnt != '0);
  assign gid      = gnt[1] ? ID_S1 : ID_S0;
  assign sel_data = gnt[1] ? s1_data : s0_data;
  assign sel_last = gnt[1] ? s1_last : s0_last;

  always_comb begin
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    m_valid_d = m_valid_q;
    rr_ptr_d  = rr_ptr_q;
    if (fire) begin
      m_data_d  = sel_data;
      m_last_d  = sel_last;
      m_id_d    = gid;
      m_valid_d = 1'b1;
      rr_ptr_d  = gid;
    end else if (load) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= ID_S0;
      m_valid_q <= 1'b0;
      rr_ptr_q  <= ID_S0;
    end else begin
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_id_q    <= m_id_d;
      m_valid_q <= m_valid_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

`ifdef STREAM_RR_MERGE_LAST_LOCK_EN
  logic lock_q, lock_d;
  logic lock_id_q, lock_id_d;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (fire) begin
      lock_d    = !sel_last;
      lock_id_d = gid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= ID_S0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  assign lock    = lock_q;
  assign lock_id = lock_id_q;
`else
  assign lock    = 1'b0;
  assign lock_id = ID_S0;
`endif

  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_id    = m_id_q;
  assign m_valid = m_valid_q;

endmodule
